sha_msg_schedule: RTL and testbench

//  Multi-mode SHA message-schedule engine: accepts one padded block, streams the W_t words one per

---
 rtl/sha.sv | 33 +++
 rtl/sha_msg_schedule.sv | 142 ++++++++++++++
 tb/tb_sha_msg_schedule.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha.sv
// Shared SHA definitions: mode encoding, block type and the message-schedule
// sigma functions used by the schedule engine.
package sha;

  typedef enum logic [2:0] {
    MODE_SHA1       = 3'd0,
    MODE_SHA224     = 3'd1,
    MODE_SHA256     = 3'd2,
    MODE_SHA384     = 3'd3,
    MODE_SHA512     = 3'd4,
    MODE_SHA512_224 = 3'd5,
    MODE_SHA512_256 = 3'd6
  } mode_t;

  typedef logic [1023:0] msg_t;

  function automatic logic [31:0] delta0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] delta1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] delta0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] delta1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

endpackage

// File: rtl/sha_msg_schedule.sv
// Multi-mode SHA message-schedule engine. Accepts one padded block and
// streams W_0..W_{R-1} one word per out handshake (R = 64 for SHA-224/256,
// 80 for SHA-1 and the 64-bit modes).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   abort           abandon current block, return to IDLE
//   in_valid/ready  block + mode handshake (in_mode is sha::mode_t encoding)
//   in_msg          padded block; 64-bit modes use [1023:0], 32-bit [511:0]
//   out_valid/ready W_t handshake towards the round core
//   out_w, out_t    W_t (32-bit modes zero-extended) and its round index
//   out_last        out_w is the final word of the block
//   err             one-cycle pulse when an unsupported mode is presented
module sha_msg_schedule #(
  parameter bit EN_SHA1   = 1'b1,
  parameter bit EN_SHA512 = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_mode,
  input  logic [1023:0] in_msg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_w,
  output logic [6:0]    out_t,
  output logic          out_last,
  output logic          err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [63:0] r_win [16];
  logic [6:0]  r_t;
  logic        r_last;
  logic        r_err;
  logic [2:0]  r_mode;

  logic        w_in_sha1;
  logic        w_in_64;
  logic        w_in_ok;
  logic        w_run_sha1;
  logic        w_run_64;
  logic [6:0]  w_last_t;
  logic [63:0] w_new;
  logic [31:0] w_sha1_x;
  logic [63:0] w_load [16];

  // Input-side mode decode and block unpacking (big-endian word order)
  always_comb begin
    w_in_sha1 = (in_mode == sha::MODE_SHA1);
    w_in_64   = (in_mode >= 3'd3) && (in_mode <= 3'd6);
    w_in_ok   = (w_in_sha1 && EN_SHA1) || (w_in_64 && EN_SHA512) ||
                (in_mode == sha::MODE_SHA224) || (in_mode == sha::MODE_SHA256);
    for (int i = 0; i < 16; i++) begin
      if (w_in_64)
        w_load[i] = in_msg[1023-64*i -: 64];
      else
        w_load[i] = {32'h0, in_msg[511-32*i -: 32]};
    end
  end

  // Recurrence for W_{t+16} from the current window
  always_comb begin
    w_run_sha1 = (r_mode == sha::MODE_SHA1);
    w_run_64   = (r_mode >= 3'd3) && (r_mode <= 3'd6);
    w_last_t   = ((r_mode == sha::MODE_SHA224) || (r_mode == sha::MODE_SHA256)) ? 7'd63 : 7'd79;
    w_sha1_x   = r_win[13][31:0] ^ r_win[8][31:0] ^ r_win[2][31:0] ^ r_win[0][31:0];
    w_new      = '0;
    if (w_run_sha1) begin
      if (EN_SHA1)
        w_new = {32'h0, w_sha1_x[30:0], w_sha1_x[31]};
    end else if (w_run_64) begin
      if (EN_SHA512)
        w_new = sha::delta1_64(r_win[14]) + r_win[9] + sha::delta0_64(r_win[1]) + r_win[0];
    end else begin
      w_new = {32'h0, sha::delta1_32(r_win[14][31:0]) + r_win[9][31:0] +
                      sha::delta0_32(r_win[1][31:0]) + r_win[0][31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_mode  <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_err <= 1'b0;
      if (abort) begin
        // A word handshaken in the same cycle is the sink's; nothing to undo.
        r_state <= ST_IDLE;
        r_t     <= '0;
        r_last  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (in_valid) begin
              if (w_in_ok) begin
                for (int i = 0; i < 16; i++) r_win[i] <= w_load[i];
                r_mode  <= in_mode;
                r_t     <= '0;
                r_last  <= 1'b0;
                r_state <= ST_RUN;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (out_ready) begin
              for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
              r_win[15] <= w_new;
              if (r_last) begin
                r_state <= ST_IDLE;
                r_t     <= '0;
                r_last  <= 1'b0;
              end else begin
                r_t    <= r_t + 7'd1;
                r_last <= ((r_t + 7'd1) == w_last_t);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = !rst && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_RUN);
  assign out_w     = r_win[0];
  assign out_t     = r_t;
  assign out_last  = r_last;
  assign err       = r_err;

endmodule

// File: tb/tb_sha_msg_schedule.sv
module tb_sha_msg_schedule;

  logic          clk = 1'b0;
  logic          rst, abort, in_valid, out_ready;
  logic [2:0]    in_mode;
  logic [1023:0] in_msg;
  logic          in_ready, out_valid, out_last, err;
  logic [63:0]   out_w;
  logic [6:0]    out_t;

  logic          n1_in_valid, n1_in_ready, n1_out_valid, n1_out_last, n1_err;
  logic [2:0]    n1_in_mode;
  logic [63:0]   n1_out_w;
  logic [6:0]    n1_out_t;

  int total = 0;
  int bad   = 0;

  logic [63:0]   exp_w [80];
  logic [63:0]   got_w [80];
  int            exp_n;
  logic [1023:0] msg32, msg64, msg_r;

  always #5 clk = ~clk;

  sha_msg_schedule u_dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_msg(in_msg), .out_valid(out_valid), .out_ready(out_ready),
    .out_w(out_w), .out_t(out_t), .out_last(out_last), .err(err)
  );

  sha_msg_schedule #(.EN_SHA1(1'b0), .EN_SHA512(1'b1)) u_dut_n1 (
    .clk(clk), .rst(rst), .abort(1'b0), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .in_mode(n1_in_mode), .in_msg(in_msg), .out_valid(n1_out_valid), .out_ready(1'b1),
    .out_w(n1_out_w), .out_t(n1_out_t), .out_last(n1_out_last), .err(n1_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Reference schedule computed over the full W[] array by round index
  task automatic build_exp(input logic [2:0] m, input logic [1023:0] msg);
    bit is64, is1;
    logic [31:0] a, s0, s1;
    logic [63:0] b0, b1;
    is64  = (m >= 3) && (m <= 6);
    is1   = (m == 0);
    exp_n = (m == 1 || m == 2) ? 64 : 80;
    for (int t = 0; t < 16; t++)
      exp_w[t] = is64 ? msg[1023-64*t -: 64] : {32'h0, msg[511-32*t -: 32]};
    for (int t = 16; t < 80; t++) begin
      if (is1) begin
        a = exp_w[t-3][31:0] ^ exp_w[t-8][31:0] ^ exp_w[t-14][31:0] ^ exp_w[t-16][31:0];
        exp_w[t] = {32'h0, rr32(a, 31)};
      end else if (is64) begin
        b0 = rr64(exp_w[t-15], 1) ^ rr64(exp_w[t-15], 8) ^ (exp_w[t-15] >> 7);
        b1 = rr64(exp_w[t-2], 19) ^ rr64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6);
        exp_w[t] = b1 + exp_w[t-7] + b0 + exp_w[t-16];
      end else begin
        a  = exp_w[t-15][31:0];
        s0 = rr32(a, 7) ^ rr32(a, 18) ^ (a >> 3);
        a  = exp_w[t-2][31:0];
        s1 = rr32(a, 17) ^ rr32(a, 19) ^ (a >> 10);
        exp_w[t] = {32'h0, s1 + exp_w[t-7][31:0] + s0 + exp_w[t-16][31:0]};
      end
    end
  endtask

  // Presents a block for one cycle; leaves the bench 1 time unit after the accepting edge
  task automatic send_block(input logic [2:0] m, input logic [1023:0] msg);
    build_exp(m, msg);
    in_valid = 1'b1;
    in_mode  = m;
    in_msg   = msg;
    #1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Walks the word stream; stalls at stall_t, returns early after showing stop_t
  task automatic consume(input int stall_t, input int stall_len, input int stop_t);
    out_ready = 1'b1;
    for (int t = 0; t < exp_n; t++) begin
      got_w[t] = out_w;
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_t", 64'(out_t), 64'(t));
      chk("out_w", out_w, exp_w[t]);
      chk("out_last", 64'(out_last), 64'(t == exp_n - 1));
      chk("err_in_run", 64'(err), 64'd0);
      if (t == stop_t) return;
      if (t == stall_t) begin
        out_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_t", 64'(out_t), 64'(t));
          chk("stall_w", out_w, exp_w[t]);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("valid_after_last", 64'(out_valid), 64'd0);
    chk("ready_after_last", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = '0; in_msg = '0; n1_in_valid = 1'b0; n1_in_mode = '0;

    msg32 = '0;
    msg32[1023:512] = {16{32'hDEADBEEF}};
    msg32[511:480]  = 32'h61626380;
    msg32[31:0]     = 32'h18;
    msg64 = '0;
    msg64[1023:960] = 64'h6162638000000000;
    msg64[63:0]     = 64'h18;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_w", out_w, 64'd0);
    chk("rst_out_t", 64'(out_t), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // SHA-256 "abc"
    send_block(3'd2, msg32);
    consume(-1, 0, -1);
    chk("sha256_t0", got_w[0], 64'h61626380);
    chk("sha256_t16", got_w[16], 64'h61626380);
    chk("sha256_t17", got_w[17], 64'h000F0000);

    // SHA-1 "abc"
    send_block(3'd0, msg32);
    consume(-1, 0, -1);
    chk("sha1_t16", got_w[16], 64'hC2C4C700);
    chk("sha1_t18", got_w[18], 64'h30);

    // SHA-512 "abc"
    send_block(3'd4, msg64);
    consume(-1, 0, -1);
    chk("sha512_t16", got_w[16], 64'h6162638000000000);
    chk("sha512_t17", got_w[17], 64'h00030000000000C0);

    // SHA-256 "abc" with sink stalled five cycles at t=20
    send_block(3'd2, msg32);
    consume(20, 5, -1);
    chk("stall_t17", got_w[17], 64'h000F0000);

    // Random blocks through each datapath
    for (int i = 0; i < 32; i++) msg_r[i*32 +: 32] = $urandom;
    send_block(3'd2, msg_r);
    consume(-1, 0, -1);
    send_block(3'd3, msg_r);
    consume(40, 2, -1);
    send_block(3'd0, msg_r);
    consume(-1, 0, -1);

    // Unsupported encoding 7
    in_valid = 1'b1; in_mode = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("err7_pulse", 64'(err), 64'd1);
    chk("err7_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("err7_cleared", 64'(err), 64'd0);
    chk("err7_idle", 64'(in_ready), 64'd1);
    chk("err7_still_no_valid", 64'(out_valid), 64'd0);

    // SHA-1 on the build without it
    n1_in_valid = 1'b1; n1_in_mode = 3'd0; in_msg = msg32;
    @(posedge clk); #1;
    n1_in_valid = 1'b0;
    chk("n1_err_pulse", 64'(n1_err), 64'd1);
    chk("n1_no_valid", 64'(n1_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("n1_err_cleared", 64'(n1_err), 64'd0);
    chk("n1_idle", 64'(n1_in_ready), 64'd1);
    n1_in_valid = 1'b1; n1_in_mode = 3'd2;
    @(posedge clk); #1;
    n1_in_valid = 1'b0;
    chk("n1_sha256_ok", 64'(n1_out_valid), 64'd1);
    chk("n1_sha256_w0", n1_out_w, 64'h61626380);
    chk("n1_sha256_noerr", 64'(n1_err), 64'd0);

    // Abort at t=30 together with out_ready, then a fresh block
    send_block(3'd2, msg32);
    consume(-1, 0, 30);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_t", 64'(out_t), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    send_block(3'd2, msg32);
    consume(-1, 0, -1);

    // Reset at t=40 of a SHA-512 block, then a fresh block
    send_block(3'd4, msg64);
    consume(-1, 0, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_t", 64'(out_t), 64'd0);
    chk("rst_mid_w", out_w, 64'd0);
    chk("rst_mid_last", 64'(out_last), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    send_block(3'd4, msg64);
    consume(-1, 0, -1);

    // Abort in IDLE blocks acceptance
    in_valid = 1'b1; in_mode = 3'd2; in_msg = msg32; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_no_accept", 64'(out_valid), 64'd0);
    chk("idle_abort_no_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    chk("idle_abort_still_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
